// File: rtl/spi_packet_sender.sv
// rtl/spi_packet_sender.sv - SPI mode-0 master sending one destination/data/checksum packet.
// Three (size+1)-bit frames, MSB first, in one chip-select window with GAP spacing between frames.

module spi_packet_sender #(
    parameter int size    = 8,
    parameter int CLK_DIV = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [size-1:0] destination,
    input  logic [size-1:0] data,
    input  logic            badCheck,
    output logic            busy,
    output logic            done,
    output logic            sclk,
    output logic            mosi,
    output logic            csN
);

    localparam int FW = size + 1;
    localparam int CW = $clog2(2 * CLK_DIV);
    localparam int BW = $clog2(FW);
    localparam logic [CW-1:0] CNT_LAST = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_HIGH = CW'(CLK_DIV);
    localparam logic [BW-1:0] BIT_LAST = BW'(size);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [1:0]    frame_q, frame_d;
    logic [FW-1:0] shreg_q, shreg_d;
    logic [FW-1:0] f1_q, f1_d;
    logic [FW-1:0] f2_q, f2_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            frame_q <= '0;
            shreg_q <= '0;
            f1_q    <= '0;
            f2_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
            shreg_q <= shreg_d;
            f1_q    <= f1_d;
            f2_q    <= f2_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        shreg_d = shreg_q;
        f1_d    = f1_q;
        f2_d    = f2_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // All three frames are captured here so later input changes cannot leak in.
                    shreg_d = {1'b0, destination};
                    f1_d    = {1'b0, data};
                    f2_d    = ({1'b0, destination} + {1'b0, data}) ^ FW'(badCheck);
                    cnt_d   = '0;
                    bit_d   = '0;
                    frame_d = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        frame_d = frame_q + 2'd1;
                        if (frame_q == 2'd2) begin
                            state_d = DONE;
                        end else begin
                            // Next frame MSB is presented for the whole gap.
                            shreg_d = (frame_q == 2'd0) ? f1_q : f2_q;
                            state_d = GAP;
                        end
                    end else begin
                        bit_d   = bit_q + BW'(1);
                        shreg_d = {shreg_q[FW-2:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GAP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == SHIFT) || (state_q == GAP);
    assign done = (state_q == DONE);
    assign csN  = !busy;
    assign sclk = (state_q == SHIFT) && (cnt_q >= CNT_HIGH);
    assign mosi = busy & shreg_q[FW-1];

endmodule

// File: tb/tb_spi_packet_sender.sv
// tb/tb_spi_packet_sender.sv - randomized self-checking bench with an SPI slave reference model.

module tb_spi_packet_sender;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] destination;
    logic [7:0] data;
    logic       badCheck;
    logic       busy;
    logic       done;
    logic       sclk;
    logic       mosi;
    logic       csN;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    spi_packet_sender #(.size(8), .CLK_DIV(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .destination (destination),
        .data        (data),
        .badCheck    (badCheck),
        .busy        (busy),
        .done        (done),
        .sclk        (sclk),
        .mosi        (mosi),
        .csN         (csN)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_packet(input logic [7:0] d, input logic [7:0] t, input logic bad,
                              input bit mid_start, input bit done_start, input string tag,
                              output logic [8:0] f2_out);
        logic [8:0]  sum;
        logic [26:0] exp_bits;
        logic [26:0] got_bits;
        int          edges, low_cnt, done_cyc, done_pulses, proto_err;
        logic        prev_sclk, prev_mosi, start_next;

        sum = {1'b0, d} + {1'b0, t};
        if (bad) sum = sum ^ 9'd1;
        exp_bits = {1'b0, d, 1'b0, t, sum};

        got_bits = '0;
        edges = 0; low_cnt = 0; done_cyc = -1; done_pulses = 0; proto_err = 0;
        prev_sclk = sclk;
        prev_mosi = mosi;
        destination = d;
        data = t;
        badCheck = bad;
        start = 1'b1;

        for (int cyc = 1; cyc <= 400; cyc++) begin
            tick();
            if (!csN) low_cnt++;
            if (csN && sclk) proto_err++;
            if (sclk && (mosi !== prev_mosi)) proto_err++;
            if (busy !== !csN) proto_err++;
            if (sclk && !prev_sclk) begin
                edges++;
                got_bits = {got_bits[25:0], mosi};
            end
            if (done) begin
                done_pulses++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            prev_sclk = sclk;
            prev_mosi = mosi;

            start_next = 1'b0;
            if (mid_start && cyc == 49) start_next = 1'b1;
            if (done_start && done) start_next = 1'b1;
            start = start_next;
            if (cyc == 1) begin
                destination = 8'($urandom);
                data = 8'($urandom);
                badCheck = 1'($urandom);
            end
            if (done_cyc > 0 && cyc >= done_cyc + 20) break;
        end
        start = 1'b0;

        chk({tag, " sclk_edges"}, edges, 27);
        chk({tag, " bits"}, got_bits, exp_bits);
        chk({tag, " csn_low_cycles"}, low_cnt, 232);
        chk({tag, " done_cycle"}, done_cyc, 233);
        chk({tag, " done_pulses"}, done_pulses, 1);
        chk({tag, " protocol_errors"}, proto_err, 0);
        f2_out = got_bits[8:0];
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " csN"}, csN, 1);
        chk({tag, " sclk"}, sclk, 0);
        chk({tag, " mosi"}, mosi, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
    endtask

    initial begin
        logic [8:0] f2;
        logic [7:0] rd, rt;
        reset = 1'b1;
        start = 1'b0;
        destination = '0;
        data = '0;
        badCheck = 1'b0;
        repeat (3) tick();
        check_idle("reset");
        reset = 1'b0;
        tick();

        run_packet(8'h02, 8'h05, 1'b0, 1'b0, 1'b0, "basic", f2);
        chk("basic f2", f2, 9'h007);
        run_packet(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, "carry", f2);
        chk("carry f2", f2, 9'h1FE);
        run_packet(8'h02, 8'h05, 1'b1, 1'b0, 1'b0, "badcheck", f2);
        chk("badcheck f2", f2, 9'h006);

        rd = 8'($urandom);
        rt = 8'($urandom);
        run_packet(rd, rt, 1'($urandom), 1'b1, 1'b1, "ignored_starts", f2);

        // Abort mid-F1 and confirm the next edge lands on reset values.
        destination = 8'($urandom);
        data = 8'($urandom);
        start = 1'b1;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            tick();
            start = 1'b0;
        end
        chk("abort busy_before", busy, 1);
        reset = 1'b1;
        tick();
        check_idle("abort");
        reset = 1'b0;
        tick();
        run_packet(8'h02, 8'h05, 1'b0, 1'b0, 1'b0, "after_abort", f2);

        for (int i = 0; i < 4; i++) begin
            rd = 8'($urandom);
            rt = 8'($urandom);
            run_packet(rd, rt, 1'($urandom), 1'($urandom), 1'($urandom), "random", f2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
